// File: rtl/noc_traffic_gen.sv
// Module: noc_traffic_gen
// NUM_CH independent flit injectors with LFSR-driven destinations, rate throttle and packet budget.
module noc_traffic_gen #(
    parameter int          BUS_WIDTH = 32,
    parameter int          NOC_SIZE  = 4,
    parameter int          LOC_X     = 0,
    parameter int          LOC_Y     = 0,
    parameter int          NUM_CH    = 5,
    parameter logic [15:0] SEED      = 16'hACE1
) (
    input  logic                          clk1,
    input  logic                          rst,
    input  logic                          enable,
    input  logic [1:0]                    mode,
    input  logic [7:0]                    rate,
    input  logic [$clog2(NOC_SIZE)-1:0]   fixed_x,
    input  logic [$clog2(NOC_SIZE)-1:0]   fixed_y,
    input  logic [15:0]                   pkt_limit,
    input  logic [NUM_CH-1:0]             bf_in,
    output logic [NUM_CH*BUS_WIDTH-1:0]   flit_out,
    output logic [NUM_CH-1:0]             flit_valid,
    output logic [NUM_CH*16-1:0]          sent_cnt,
    output logic                          done
);

    localparam int AW  = $clog2(NOC_SIZE);
    localparam int HW  = 1 + 4*AW;
    localparam int REP = (BUS_WIDTH - HW - 16) / 16 + 1;
    localparam logic [AW-1:0] LX = AW'(LOC_X);
    localparam logic [AW-1:0] LY = AW'(LOC_Y);
    localparam logic [BUS_WIDTH-1:0] LOW_MASK = {{HW{1'b0}}, {(BUS_WIDTH-HW){1'b1}}};

    typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_t;

    logic [NUM_CH-1:0] ch_done;

    // Payload is the LFSR repeated upward from bit 16; the header mask trims whatever overlaps it.
    function automatic logic [BUS_WIDTH-1:0] make_flit(input logic [AW-1:0] dx,
                                                       input logic [AW-1:0] dy,
                                                       input logic [15:0]   pl,
                                                       input logic [15:0]   sq);
        logic [REP*16+15:0] body;
        body = {{REP{pl}}, sq};
        return (BUS_WIDTH'(body) & LOW_MASK) | {1'b1, dx, dy, LX, LY, {(BUS_WIDTH-HW){1'b0}}};
    endfunction

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        localparam logic [15:0] SEED_MIX = SEED ^ 16'(16'h01D3 * (c + 1));
        localparam logic [15:0] SEED_C   = (SEED_MIX == 16'h0000) ? 16'h0001 : SEED_MIX;

        state_t                state, state_nx;
        logic [15:0]           lfsr, lfsr_step;
        logic [15:0]           cnt, cnt_nx, cnt_inc, seq, seq_nx;
        logic [BUS_WIDTH-1:0]  flit, flit_nx;
        logic                  vld, vld_nx, load_cfg, fire, xfer;
        logic [1:0]            mode_q;
        logic [7:0]            rate_q;
        logic [AW-1:0]         fx_q, fy_q, dst_x, dst_y;
        logic [15:0]           lim_q;

        assign lfsr_step = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
        assign fire      = (lfsr[7:0] < rate_q) || (rate_q == 8'hFF);
        assign xfer      = vld && !bf_in[c];
        assign cnt_inc   = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;

        always_comb begin
            dst_x = fx_q;
            dst_y = fy_q;
            case (mode_q)
                2'd0: begin
                    dst_x = lfsr[AW-1:0];
                    dst_y = lfsr[2*AW-1:AW];
                    if (dst_x == LX && dst_y == LY) dst_x = dst_x + AW'(1);
                end
                2'd1: begin
                    dst_x = LY;
                    dst_y = LX;
                end
                default: ;
            endcase
        end

        always_comb begin
            state_nx = state;
            cnt_nx   = cnt;
            seq_nx   = seq;
            flit_nx  = flit;
            vld_nx   = vld;
            load_cfg = 1'b0;
            case (state)
                IDLE: if (enable) begin
                    state_nx = RUN;
                    cnt_nx   = '0;
                    load_cfg = 1'b1;
                end
                RUN: begin
                    if (!enable) state_nx = IDLE;
                    else if (lim_q != '0 && cnt == lim_q) state_nx = DONE;
                    else if (fire) begin
                        flit_nx  = make_flit(dst_x, dst_y, lfsr, seq);
                        vld_nx   = 1'b1;
                        state_nx = HOLD;
                    end
                end
                HOLD: if (xfer) begin
                    // A transfer frees the slot; reload on the same edge only if still eligible.
                    cnt_nx  = cnt_inc;
                    seq_nx  = seq + 16'd1;
                    flit_nx = '0;
                    vld_nx  = 1'b0;
                    if (!enable) state_nx = IDLE;
                    else if (lim_q != '0 && cnt_inc == lim_q) state_nx = DONE;
                    else if (fire) begin
                        flit_nx = make_flit(dst_x, dst_y, lfsr, seq + 16'd1);
                        vld_nx  = 1'b1;
                    end else state_nx = RUN;
                end
                DONE: if (!enable) state_nx = IDLE;
            endcase
        end

        always_ff @(posedge clk1 or negedge rst) begin
            if (!rst) begin
                state  <= IDLE;
                lfsr   <= SEED_C;
                cnt    <= '0;
                seq    <= '0;
                flit   <= '0;
                vld    <= 1'b0;
                mode_q <= '0;
                rate_q <= '0;
                fx_q   <= '0;
                fy_q   <= '0;
                lim_q  <= '0;
            end else begin
                state <= state_nx;
                cnt   <= cnt_nx;
                seq   <= seq_nx;
                flit  <= flit_nx;
                vld   <= vld_nx;
                if (state != IDLE) lfsr <= lfsr_step;
                if (load_cfg) begin
                    mode_q <= mode;
                    rate_q <= rate;
                    fx_q   <= fixed_x;
                    fy_q   <= fixed_y;
                    lim_q  <= pkt_limit;
                end
            end
        end

        assign flit_out[c*BUS_WIDTH +: BUS_WIDTH] = flit;
        assign flit_valid[c]                      = vld;
        assign sent_cnt[c*16 +: 16]               = cnt;
        assign ch_done[c]                         = (state == DONE);
    end

    always_ff @(posedge clk1 or negedge rst) begin
        if (!rst) done <= 1'b0;
        else      done <= &ch_done;
    end

endmodule

// File: tb/tb_noc_traffic_gen.sv
// Bench for noc_traffic_gen at mesh node (1,2) of a 4x4 mesh with five channels.
module tb_noc_traffic_gen;

    localparam int BW  = 32;
    localparam int NCH = 5;

    logic              clk1 = 1'b0;
    logic              rst = 1'b1;
    logic              enable = 1'b0;
    logic [1:0]        mode = '0;
    logic [7:0]        rate = '0;
    logic [1:0]        fixed_x = '0, fixed_y = '0;
    logic [15:0]       pkt_limit = '0;
    logic [NCH-1:0]    bf_in = '0;
    logic [NCH*BW-1:0] flit_out;
    logic [NCH-1:0]    flit_valid;
    logic [NCH*16-1:0] sent_cnt;
    logic              done;

    noc_traffic_gen #(
        .BUS_WIDTH(BW), .NOC_SIZE(4), .LOC_X(1), .LOC_Y(2), .NUM_CH(NCH), .SEED(16'hACE1)
    ) dut (
        .clk1(clk1), .rst(rst), .enable(enable), .mode(mode), .rate(rate),
        .fixed_x(fixed_x), .fixed_y(fixed_y), .pkt_limit(pkt_limit), .bf_in(bf_in),
        .flit_out(flit_out), .flit_valid(flit_valid), .sent_cnt(sent_cnt), .done(done)
    );

    always #5 clk1 = ~clk1;

    int n_pass = 0, n_total = 0;

    task automatic check(input string name, input logic [NCH*BW-1:0] act, input logic [NCH*BW-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: per-channel "started / finished / holding a flit" view of the rules.
    logic [15:0]   m_lfsr[NCH], m_cnt[NCH], m_seq[NCH], m_lim[NCH];
    logic [7:0]    m_rate[NCH];
    logic [1:0]    m_mode[NCH], m_fx[NCH], m_fy[NCH];
    bit            m_on[NCH], m_fin[NCH], m_hold[NCH];
    logic [BW-1:0] m_flit[NCH];
    bit            m_done;

    function automatic logic [15:0] lfsr_adv(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    function automatic logic [BW-1:0] model_flit(input int c, input logic [15:0] l, input logic [15:0] s);
        int x, y;
        case (m_mode[c])
            2'd0: begin
                x = l % 4;
                y = (l / 4) % 4;
                if (x == 1 && y == 2) x = (x + 1) % 4;
            end
            2'd1: begin x = 2; y = 1; end
            default: begin x = m_fx[c]; y = m_fy[c]; end
        endcase
        return {1'b1, 2'(x), 2'(y), 2'd1, 2'd2, l[6:0], s};
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_lfsr[c] = 16'hACE1 ^ 16'(16'h01D3 * (c + 1));
            if (m_lfsr[c] == 16'h0) m_lfsr[c] = 16'h0001;
            m_cnt[c] = '0; m_seq[c] = '0; m_lim[c] = '0; m_rate[c] = '0;
            m_mode[c] = '0; m_fx[c] = '0; m_fy[c] = '0;
            m_on[c] = 0; m_fin[c] = 0; m_hold[c] = 0; m_flit[c] = '0;
        end
        m_done = 0;
    endtask

    task automatic model_load(input int c);
        m_flit[c] = model_flit(c, m_lfsr[c], m_seq[c]);
        m_hold[c] = 1;
    endtask

    task automatic model_step();
        bit all_fin, fire, at_lim;
        all_fin = 1;
        for (int c = 0; c < NCH; c++) all_fin &= m_fin[c];
        for (int c = 0; c < NCH; c++) begin
            fire = (m_rate[c] == 8'hFF) || (m_lfsr[c][7:0] < m_rate[c]);
            if (!m_on[c]) begin
                if (enable) begin
                    m_on[c] = 1; m_cnt[c] = '0;
                    m_mode[c] = mode; m_rate[c] = rate; m_fx[c] = fixed_x;
                    m_fy[c] = fixed_y; m_lim[c] = pkt_limit;
                end
            end else begin
                if (m_hold[c]) begin
                    if (!bf_in[c]) begin
                        if (m_cnt[c] != 16'hFFFF) m_cnt[c]++;
                        m_seq[c]++;
                        m_hold[c] = 0; m_flit[c] = '0;
                        at_lim = (m_lim[c] != 0) && (m_cnt[c] == m_lim[c]);
                        if (!enable) m_on[c] = 0;
                        else if (at_lim) m_fin[c] = 1;
                        else if (fire) model_load(c);
                    end
                end else if (m_fin[c]) begin
                    if (!enable) begin m_fin[c] = 0; m_on[c] = 0; end
                end else begin
                    at_lim = (m_lim[c] != 0) && (m_cnt[c] == m_lim[c]);
                    if (!enable) m_on[c] = 0;
                    else if (at_lim) m_fin[c] = 1;
                    else if (fire) model_load(c);
                end
                m_lfsr[c] = lfsr_adv(m_lfsr[c]);
            end
        end
        m_done = all_fin;
    endtask

    always @(posedge clk1 or negedge rst) begin
        if (!rst) model_reset();
        else      model_step();
    end

    // Per-cycle comparison plus destination statistics of transferred flits.
    int collect = 0, m1_flits = 0, m1_bad = 0, m0_flits = 0;
    int hist[16];
    logic [NCH-1:0]    prev_valid = '0;
    logic [NCH*BW-1:0] prev_flit = '0;
    logic [NCH*BW-1:0] exp_f;
    logic [NCH-1:0]    exp_v;
    logic [NCH*16-1:0] exp_c;
    logic [BW-1:0]     tf;
    int                tx, ty;

    always @(posedge clk1) begin
        #2;
        if (rst) begin
            for (int c = 0; c < NCH; c++) begin
                exp_f[c*BW +: BW] = m_flit[c];
                exp_v[c]          = m_hold[c];
                exp_c[c*16 +: 16] = m_cnt[c];
            end
            check("cyc_flit_out", flit_out, exp_f);
            check("cyc_flit_valid", flit_valid, exp_v);
            check("cyc_sent_cnt", sent_cnt, exp_c);
            check("cyc_done", done, m_done);
            for (int c = 0; c < NCH; c++) begin
                if (prev_valid[c] && !bf_in[c]) begin
                    tf = prev_flit[c*BW +: BW];
                    tx = tf[30:29];
                    ty = tf[28:27];
                    if (collect == 1) begin
                        m1_flits++;
                        if (tx != 2 || ty != 1) m1_bad++;
                    end else if (collect == 2) begin
                        m0_flits++;
                        hist[tx + 4*ty]++;
                    end
                end
            end
            prev_valid = flit_valid;
            prev_flit  = flit_out;
        end else begin
            prev_valid = '0;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk1);
    endtask

    task automatic wait_done(input int budget, input string name);
        int k;
        k = 0;
        while (done !== 1'b1 && k < budget) begin
            @(negedge clk1);
            k++;
        end
        check(name, done, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not reach the end by %0t", $time);
        $fatal(1, "global timeout");
    end

    int n, seen, nodes;

    initial begin
        #1 rst = 1'b0;
        #1;
        check("reset_flit_out", flit_out, '0);
        check("reset_valid", flit_valid, '0);
        check("reset_cnt", sent_cnt, '0);
        check("reset_done", done, 1'b0);

        // Reset asserted mid-run while flits are held
        cyc(1); rst = 1'b1;
        cyc(1); mode = 2'd2; fixed_x = 2'd3; fixed_y = 2'd0; rate = 8'hFF; pkt_limit = 16'd0; enable = 1'b1;
        cyc(6); bf_in = '1;
        cyc(3);
        check("t1_cnt_ch0_before_reset", sent_cnt[15:0], 16'd4);
        check("t1_valid_before_reset", flit_valid, 5'h1F);
        @(posedge clk1); #3;
        rst = 1'b0;
        #1;
        check("t1_async_flit_out", flit_out, '0);
        check("t1_async_valid", flit_valid, '0);
        check("t1_async_cnt", sent_cnt, '0);
        check("t1_async_done", done, 1'b0);
        cyc(1); enable = 1'b0; bf_in = '0;
        cyc(1); rst = 1'b1;

        // Fixed destination, full rate, 10-flit budget
        cyc(1); mode = 2'd2; fixed_x = 2'd3; fixed_y = 2'd0; rate = 8'hFF; pkt_limit = 16'd10; enable = 1'b1;
        n = 0;
        while (n < 40) begin
            @(posedge clk1); #2;
            n++;
            if (n == 1) check("t2_no_valid_on_enable_edge", flit_valid, 5'h00);
            if (n == 2) begin
                check("t2_ch0_first_flit", flit_out[31:0], 32'hE332_0000);
                check("t2_ch4_header", flit_out[159:151], 9'h1C6);
            end
            if (n == 3) check("t2_ch0_second_flit", flit_out[31:0], 32'hE319_0001);
            if (sent_cnt == {5{16'd10}}) break;
        end
        check("t2_edges_to_last_xfer", n, 12);
        check("t2_done_low_at_last_xfer", done, 1'b0);
        @(posedge clk1); #2;
        check("t2_done_next_cycle", done, 1'b1);
        check("t2_cnt_all_10", sent_cnt, {5{16'd10}});

        // Backpressure on channel 2 only
        cyc(1); enable = 1'b0;
        cyc(2); pkt_limit = 16'd0; enable = 1'b1;
        cyc(4); bf_in = 5'b00100;
        check("t3_ch2_valid", flit_valid[2], 1'b1);
        check("t3_ch2_header", flit_out[64+31 -: 9], 9'h1C6);
        check("t3_ch2_seq", flit_out[64 +: 16], 16'd12);
        repeat (7) begin
            @(posedge clk1); #2;
            check("t3_ch2_flit_stable", flit_out[64 +: 32], m_flit[2]);
            check("t3_ch2_cnt_frozen", sent_cnt[32 +: 16], 16'd2);
        end
        check("t3_ch0_kept_going", sent_cnt[15:0], 16'd9);
        check("t3_ch4_kept_going", sent_cnt[64 +: 16], 16'd9);

        // Transpose, then uniform random
        cyc(1); bf_in = '0; enable = 1'b0;
        cyc(3); collect = 1; mode = 2'd1; pkt_limit = 16'd20; rate = 8'hFF; enable = 1'b1;
        wait_done(100, "t4_mode1_done");
        collect = 0;
        check("t4_mode1_flits", m1_flits, 100);
        check("t4_mode1_bad_dst", m1_bad, 0);
        cyc(1); enable = 1'b0;
        cyc(2); collect = 2; mode = 2'd0; pkt_limit = 16'd200; enable = 1'b1;
        wait_done(600, "t4_mode0_done");
        collect = 0;
        check("t4_mode0_flits", m0_flits, 1000);
        check("t4_mode0_no_self", hist[9], 0);
        nodes = 0;
        for (int i = 0; i < 16; i++) if (i != 9 && hist[i] > 0) nodes++;
        check("t4_mode0_nodes_hit", nodes, 15);

        // Zero rate never injects
        cyc(1); enable = 1'b0;
        cyc(2); rate = 8'h00; pkt_limit = 16'd5; mode = 2'd2; enable = 1'b1;
        seen = 0;
        repeat (200) begin
            @(negedge clk1);
            if (flit_valid != '0 || done) seen++;
        end
        check("t5_no_traffic", seen, 0);

        // Disable while held: the flit still transfers once, then idle
        cyc(1); enable = 1'b0;
        cyc(2); rate = 8'hFF; pkt_limit = 16'd0; bf_in = '1; enable = 1'b1;
        cyc(4);
        check("t6_all_held", flit_valid, 5'h1F);
        check("t6_cnt_zero", sent_cnt, '0);
        enable = 1'b0;
        cyc(3);
        check("t6_held_after_disable", flit_valid, 5'h1F);
        bf_in = '0;
        @(posedge clk1); #2;
        check("t6_valid_dropped", flit_valid, 5'h00);
        check("t6_one_transfer", sent_cnt, {5{16'd1}});
        cyc(5);
        check("t6_stays_idle_valid", flit_valid, 5'h00);
        check("t6_stays_idle_flit", flit_out, '0);
        check("t6_stays_idle_cnt", sent_cnt, {5{16'd1}});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
